// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// parity-type constants and the expected-parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest data word the parity helper accepts; narrower words are zero-padded.
  localparam int MAX_DATA_WIDTH = 32;

  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      typ);
    return (typ == PAR_EVEN) ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: tick and bit counters plus the sample point.
// Build option UART_RX_MAJORITY_EN selects a 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int PRESCALE  = 8,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 active,
  input  logic                 start,
  output logic                 sampled_bit,
  output logic                 sample_strobe,
  output logic                 bit_end,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int TICK_W = $clog2(PRESCALE);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(PRESCALE - 1);

  // tick holds the index (within the current bit) of the upcoming clock edge,
  // so the start edge itself counts as tick 0.
  logic [TICK_W-1:0] tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick    <= '0;
      bit_cnt <= '0;
    end else if (!active) begin
      tick    <= start ? TICK_W'(1) : '0;
      bit_cnt <= '0;
    end else if (bit_end) begin
      tick    <= '0;
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  assign bit_end = active && (tick == LAST_TICK);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TICK_W-1:0] DECIDE_TICK = TICK_W'(PRESCALE / 2 + 1);

  // hist[0]/hist[1] hold the line one and two edges back: ticks P/2 and P/2-1
  // when the decision is taken at tick P/2+1.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_in};
    end
  end

  assign sample_strobe = active && (tick == DECIDE_TICK);
  assign sampled_bit   = (hist[0] & hist[1]) | (hist[0] & rx_in) | (hist[1] & rx_in);
`else
  localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(PRESCALE / 2);

  assign sample_strobe = active && (tick == MID_TICK);
  assign sampled_bit   = rx_in;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / data (LSB first) / optional parity / stop framing with
// registered result strobes. Build option UART_RX_MAJORITY_EN enables majority sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  party_en,
  input  logic                  party_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);

  rx_state_e state, next_state;

  logic                  active, start, frame_done;
  logic                  sampled_bit, sample_strobe, bit_end;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q, par_typ_q;
  logic                  start_bad, par_mis, stop_bad;
  logic                  start_bad_now, stop_bad_now;
  logic [MAX_DATA_WIDTH-1:0] par_word;

  assign active     = (state != IDLE);
  assign start      = (state == IDLE) && !RX_IN;
  assign frame_done = (state == STOP) && bit_end;

  // With majority sampling at small prescales the decision can land on the
  // bit's last tick, so the fresh sample is used directly in that case.
  assign start_bad_now = sample_strobe ? sampled_bit  : start_bad;
  assign stop_bad_now  = sample_strobe ? !sampled_bit : stop_bad;

  uart_rx_sampler #(
    .PRESCALE  (PRESCALE),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_sampler (
    .clk           (CLK),
    .rst           (RST),
    .rx_in         (RX_IN),
    .active        (active),
    .start         (start),
    .sampled_bit   (sampled_bit),
    .sample_strobe (sample_strobe),
    .bit_end       (bit_end),
    .bit_cnt       (bit_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (bit_end) next_state = start_bad_now ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                 next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    par_word                 = '0;
    par_word[DATA_WIDTH-1:0] = shift_reg;
  end

  // data_valid/par_err/stp_err are single-cycle strobes with no backpressure:
  // the consumer must take P_DATA in the cycle data_valid is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      start_bad  <= 1'b0;
      par_mis    <= 1'b0;
      stop_bad   <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (start) begin
        par_en_q  <= party_en;
        par_typ_q <= party_typ;
        start_bad <= 1'b0;
        par_mis   <= 1'b0;
        stop_bad  <= 1'b0;
      end
      if (sample_strobe) begin
        case (state)
          START:   start_bad <= sampled_bit;
          DATA:    shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          PARITY:  par_mis   <= (sampled_bit != calc_parity(par_word, par_typ_q));
          STOP:    stop_bad  <= !sampled_bit;
          default: ;
        endcase
      end
      if (frame_done) begin
        if (!par_mis && !stop_bad_now) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
        par_err <= par_mis;
        stp_err <= stop_bad_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model predicts strobe cycles, P_DATA
// and busy windows; one process compares every cycle, plus literal checks.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          party_en = 1'b0;
  logic          party_typ = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, busy;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .party_en   (party_en),
    .party_typ  (party_typ),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct {
    int unsigned   at;
    logic          good;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           ev_q[$];
  int unsigned   win_lo[$], win_hi[$];
  int unsigned   rst_q[$];
  int unsigned   dv_seen[$], pe_seen[$], se_seen[$];
  logic [DW-1:0] dv_data[$];
  logic [DW-1:0] exp_pdata = '0;
  logic          e_dv, e_pe, e_se, e_busy;
  ev_t           ev;
  bit            cmp_on = 1'b0;
  int unsigned   cmp_from = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic void model_reset(input int unsigned r);
    foreach (win_hi[i]) if (win_hi[i] >= r) win_hi[i] = r - 1;
    for (int i = ev_q.size() - 1; i >= 0; i--) if (ev_q[i].at >= r) ev_q.delete(i);
    rst_q.push_back(r);
    if (!cmp_on) begin
      cmp_on   = 1'b1;
      cmp_from = r;
    end
  endfunction

  function automatic int unsigned q_last(input int unsigned q[$]);
    return (q.size() > 0) ? q[q.size()-1] : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: every-cycle compare ----------------
  initial forever begin
    @(posedge CLK);
    #1;
    if (cmp_on && cyc >= cmp_from) begin
      e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0; e_busy = 1'b0;
      while (rst_q.size() > 0 && rst_q[0] <= cyc) begin
        void'(rst_q.pop_front());
        exp_pdata = '0;
      end
      while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        ev = ev_q.pop_front();
        e_dv = ev.good; e_pe = ev.pe; e_se = ev.se;
        if (ev.good) exp_pdata = ev.data;
      end
      foreach (win_lo[i]) if (cyc >= win_lo[i] && cyc <= win_hi[i]) e_busy = 1'b1;
      checks++;
      if ({busy, data_valid, par_err, stp_err, P_DATA} !== {e_busy, e_dv, e_pe, e_se, exp_pdata}) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual busy=%b dv=%b pe=%b se=%b P_DATA=%h expected busy=%b dv=%b pe=%b se=%b P_DATA=%h",
                 cyc, busy, data_valid, par_err, stp_err, P_DATA, e_busy, e_dv, e_pe, e_se, exp_pdata);
      end
      if (data_valid === 1'b1) begin
        dv_seen.push_back(cyc);
        dv_data.push_back(P_DATA);
      end
      if (par_err === 1'b1) pe_seen.push_back(cyc);
      if (stp_err === 1'b1) se_seen.push_back(cyc);
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives one frame; abort_at >= 0 pulses RST at that tick, glitch_at >= 0
  // inverts the line for one cycle at that tick.
  task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_bit,
                            input int abort_at, input int glitch_at,
                            output int unsigned t0);
    int          n;
    logic [11:0] bits;
    n    = pen ? DW + 3 : DW + 2;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = data[i];
    if (pen) bits[DW+1] = (^data) ^ ptyp ^ bad_par;
    bits[n-1] = stop_bit;
    t0 = 0;
    for (int i = 0; i < n * P; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        t0        = cyc + 1;
        party_en  = pen;
        party_typ = ptyp;
        ev_q.push_back('{at: t0 + n*P - 1, good: !(pen && bad_par) && stop_bit,
                         pe: pen && bad_par, se: !stop_bit, data: data});
        win_lo.push_back(t0);
        win_hi.push_back(t0 + n*P - 2);
      end
      if (i == 3 * P) begin
        party_en  = ~pen;
        party_typ = ~ptyp;
      end
      if (i == abort_at) begin
        RST   = 1'b1;
        RX_IN = 1'b1;
        model_reset(cyc + 1);
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
      RX_IN = (i == glitch_at) ? ~bits[i/P] : bits[i/P];
    end
  endtask

  task automatic short_low(input int low_cycles, output int unsigned t0);
    @(negedge CLK);
    t0    = cyc + 1;
    RX_IN = 1'b0;
    win_lo.push_back(t0);
    win_hi.push_back(t0 + P - 2);
    repeat (low_cycles) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int unsigned t, t2, n;

  initial begin
    repeat (2) begin
      @(negedge CLK);
      RST = 1'b1;
      model_reset(cyc + 1);
    end
    @(negedge CLK);
    RST = 1'b0;
    check("rst_pdata", P_DATA, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {data_valid, par_err, stp_err}, 0);

    // Good frame with even parity: 11 bits, strobe after edge T+87.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, t);
    idle(3);
    check("a5_latency", q_last(dv_seen) - t, 87);
    check("a5_data", P_DATA, 8'hA5);

    // Odd parity expected 1 for 0x3C, 0 sent.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, t);
    idle(3);
    check("3c_pe_latency", q_last(pe_seen) - t, 87);
    check("3c_pdata_held", P_DATA, 8'hA5);
    check("3c_no_dv", dv_seen.size(), 1);

    // Stop error, then the line stays low straight into a good frame.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, t);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t2);
    idle(3);
    check("5a_se_latency", q_last(se_seen) - t, 79);
    check("81_latency", q_last(dv_seen) - t2, 79);
    check("81_data", P_DATA, 8'h81);

    // Two-cycle low pulse: rejected as a glitch.
    short_low(2, t);
    repeat (P) @(negedge CLK);
    check("glitch_busy", busy, 0);
    check("glitch_no_dv", dv_seen.size(), 2);

    // Three frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    idle(3);
    n = dv_seen.size();
    check("b2b_count", n, 5);
    if (n >= 5) begin
      check("b2b_gap1", dv_seen[n-2] - dv_seen[n-3], 80);
      check("b2b_gap2", dv_seen[n-1] - dv_seen[n-2], 80);
      check("b2b_d0", dv_data[n-3], 8'h00);
      check("b2b_d1", dv_data[n-2], 8'hFF);
      check("b2b_d2", dv_data[n-1], 8'h55);
    end

    // Parity and stop errors together, followed immediately by a good frame.
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, t);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t2);
    idle(3);
    check("both_pe_at", q_last(pe_seen) - t, 87);
    check("both_se_at", q_last(se_seen) - t, 87);
    check("66_data", P_DATA, 8'h66);

    // Reset at tick 30 of a frame, then a clean frame.
    send_frame(8'hE7, 1'b0, 1'b0, 1'b0, 1'b1, 30, -1, t);
    idle(4);
    check("midrst_pdata", P_DATA, 0);
    check("midrst_busy", busy, 0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    idle(3);
    check("12_latency", q_last(dv_seen) - t, 79);
    check("12_data", P_DATA, 8'h12);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inversion at mid-bit of data bit 2 is outvoted.
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3*P + P/2, t);
    idle(3);
    check("maj_data", P_DATA, 8'hC3);
    check("dv_total", dv_seen.size(), 8);
`else
    check("dv_total", dv_seen.size(), 7);
`endif
    check("pe_total", pe_seen.size(), 2);
    check("se_total", se_seen.size(), 2);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
